// File: rtl/placar_exibidor_bcd.sv
// placar_exibidor_bcd: serial binary-to-BCD score converter driving a scanned 3-digit 7-segment display
module placar_exibidor_bcd #(
    parameter int W               = 7,
    parameter int SCAN_DIV        = 4,
    parameter int SEG_ATIVO_BAIXO = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] placar,
    input  logic         carregar,
    output logic         ocupado,
    output logic         pronto,
    output logic [3:0]   centena,
    output logic [3:0]   dezena,
    output logic [3:0]   unidade,
    output logic [6:0]   seg,
    output logic [2:0]   an
);
    localparam int CW = $clog2(W + 1);
    localparam int SW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
    typedef enum logic [1:0] {OCIOSO, CONVERTE, FIM} estado_t;
    estado_t estado, prox;
    logic [W-1:0]  bin;
    logic [11:0]   bcd, ajust;
    logic [CW-1:0] cnt;
    logic [SW-1:0] scnt;
    logic [3:0]    sel;
    logic [6:0]    hi;
    logic          blank;
    for (genvar g = 0; g < 3; g++) begin : g_aj
        assign ajust[4*g +: 4] = bcd[4*g +: 4] >= 4'd5 ? bcd[4*g +: 4] + 4'd3 : bcd[4*g +: 4];
    end
    assign ocupado = estado != OCIOSO;
    always_comb begin
        prox = estado;
        prox = estado == OCIOSO   ? (carregar ? CONVERTE : OCIOSO)
             : estado == CONVERTE ? (cnt == CW'(1) ? FIM : CONVERTE)
             : OCIOSO;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            estado  <= OCIOSO;
            pronto  <= 1'b0;
            centena <= '0;
            dezena  <= '0;
            unidade <= '0;
            bin     <= '0;
            bcd     <= '0;
            cnt     <= '0;
        end else begin
            estado <= prox;
            pronto <= estado == FIM;
            if (estado == OCIOSO && carregar) begin
                bin <= placar;
                bcd <= '0;
                cnt <= CW'(W);
            end
            if (estado == CONVERTE) begin
                bcd <= {ajust[10:0], bin[W-1]};
                bin <= {bin[W-2:0], 1'b0};
                cnt <= cnt - 1'b1;
            end
            if (estado == FIM) begin
                centena <= bcd[11:8];
                dezena  <= bcd[7:4];
                unidade <= bcd[3:0];
            end
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scnt <= '0;
            an   <= 3'b001;
        end else begin
            scnt <= scnt == SW'(SCAN_DIV - 1) ? '0 : scnt + 1'b1;
            if (scnt == SW'(SCAN_DIV - 1))
                an <= {an[1:0], an[2]};
        end
    end
    function automatic logic [6:0] dec(input logic [3:0] d);
        case (d)
            4'd0:    dec = 7'b0111111;
            4'd1:    dec = 7'b0000110;
            4'd2:    dec = 7'b1011011;
            4'd3:    dec = 7'b1001111;
            4'd4:    dec = 7'b1100110;
            4'd5:    dec = 7'b1101101;
            4'd6:    dec = 7'b1111101;
            4'd7:    dec = 7'b0000111;
            4'd8:    dec = 7'b1111111;
            4'd9:    dec = 7'b1101111;
            default: dec = 7'b0000000;
        endcase
    endfunction
    // leading-zero blanking uses only registered digits, so the display never shows partial results
    assign sel   = an[0] ? unidade : an[1] ? dezena : centena;
    assign blank = (an[2] && centena == 4'd0) || (an[1] && centena == 4'd0 && dezena == 4'd0);
    assign hi    = blank ? 7'b0000000 : dec(sel);
    assign seg   = SEG_ATIVO_BAIXO != 0 ? ~hi : hi;
endmodule

// File: tb/tb_placar_exibidor_bcd.sv
// tb_placar_exibidor_bcd: checks the BCD scoreboard reader against a cycle-level arithmetic model
module tb_placar_exibidor_bcd;
    localparam int W = 7;
    localparam int SCAN_DIV = 4;
    logic       clk = 0, rst_n = 0, carregar = 0;
    logic [6:0] placar = 0;
    logic       ocupado, pronto;
    logic [3:0] centena, dezena, unidade;
    logic [6:0] seg;
    logic [2:0] an;
    int total = 0, bad = 0;
    bit chk_en = 0;
    // model state
    int m_left = 0, m_val = 0, m_c = 0, m_d = 0, m_u = 0, m_k = 0;
    bit m_pronto = 0;
    logic [6:0] pat [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                              7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    placar_exibidor_bcd #(.W(W), .SCAN_DIV(SCAN_DIV), .SEG_ATIVO_BAIXO(1)) dut (
        .clk(clk), .rst_n(rst_n), .placar(placar), .carregar(carregar),
        .ocupado(ocupado), .pronto(pronto), .centena(centena), .dezena(dezena),
        .unidade(unidade), .seg(seg), .an(an));

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            m_left = 0; m_c = 0; m_d = 0; m_u = 0; m_k = 0; m_pronto = 0;
        end else begin
            m_k++;
            m_pronto = 0;
            if (m_left == 0) begin
                if (carregar) begin m_left = W + 1; m_val = placar; end
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_c = m_val / 100; m_d = (m_val / 10) % 10; m_u = m_val % 10; m_pronto = 1;
                end
            end
        end
    end

    function automatic int exp_seg(input int idx);
        if (idx == 2 && m_c == 0) return 7'b1111111;
        if (idx == 1 && m_c == 0 && m_d == 0) return 7'b1111111;
        return pat[idx == 0 ? m_u : idx == 1 ? m_d : m_c];
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            int idx;
            idx = (m_k / SCAN_DIV) % 3;
            chk("ocupado", ocupado, m_left != 0);
            chk("pronto", pronto, m_pronto);
            chk("centena", centena, m_c);
            chk("dezena", dezena, m_d);
            chk("unidade", unidade, m_u);
            chk("an", an, 1 << idx);
            chk("seg", seg, exp_seg(idx));
        end
    end

    task automatic wait_pronto(output int n);
        n = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (pronto) begin n = i; return; end
        end
        chk("pronto_timeout", 0, 1);
    endtask

    task automatic conv(input int v, output int n);
        placar = 7'(v); carregar = 1;
        @(negedge clk);
        carregar = 0;
        wait_pronto(n);
        n++;
    endtask

    initial begin
        int n, busy;
        bit seen;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk_en = 1;
        chk("rst_ocupado", ocupado, 0);
        chk("rst_pronto", pronto, 0);
        chk("rst_digits", {centena, dezena, unidade}, 0);
        chk("rst_an", an, 3'b001);
        chk("rst_seg", seg, 7'b1000000);
        rst_n = 1;
        // 127: count busy cycles while waiting for pronto
        placar = 127; carregar = 1;
        @(negedge clk);
        carregar = 0;
        busy = 0;
        for (int i = 0; i < 30 && !pronto; i++) begin
            busy += ocupado;
            @(negedge clk);
        end
        chk("busy_cycles_127", busy, 8);
        chk("pronto_127", pronto, 1);
        chk("lit_127", {centena, dezena, unidade}, 12'h127);
        chk("model_127", m_c * 100 + m_d * 10 + m_u, 127);
        // 5: wait until each digit position is lit
        conv(5, n);
        chk("lit_5", {centena, dezena, unidade}, 12'h005);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (an == 3'b001) chk("seg5_units", seg, 7'b0010010);
            else chk("seg5_blank", seg, 7'b1111111);
        end
        conv(100, n);
        chk("lit_100", {centena, dezena, unidade}, 12'h100);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (an == 3'b010) chk("seg100_tens", seg, 7'b1000000);
        end
        conv(0, n);
        chk("lit_0", {centena, dezena, unidade}, 12'h000);
        // 45 with placar switched mid-conversion, then back-to-back 99
        placar = 45; carregar = 1;
        @(negedge clk);
        carregar = 0;
        @(negedge clk);
        @(negedge clk);
        placar = 99;
        wait_pronto(n);
        chk("lit_45", {centena, dezena, unidade}, 12'h045);
        carregar = 1;
        @(negedge clk);
        carregar = 0;
        wait_pronto(n);
        chk("b2b_latency", n + 1, 9);
        chk("lit_99", {centena, dezena, unidade}, 12'h099);
        // reset mid-conversion
        placar = 88; carregar = 1;
        @(negedge clk);
        carregar = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 0;
        @(negedge clk);
        chk("abort_ocupado", ocupado, 0);
        chk("abort_digits", {centena, dezena, unidade}, 0);
        rst_n = 1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            seen |= pronto;
        end
        chk("abort_no_pronto", seen, 0);
        // full sweep
        for (int v = 0; v < 128; v++) begin
            conv(v, n);
            chk("sweep", centena * 100 + dezena * 10 + unidade, v);
        end
        // random inputs, including held carregar and occasional resets
        for (int i = 0; i < 1500; i++) begin
            placar = 7'($urandom_range(0, 127));
            carregar = $urandom_range(0, 2) != 0;
            rst_n = $urandom_range(0, 60) != 0;
            @(negedge clk);
        end
        rst_n = 1; carregar = 0;
        repeat (12) @(negedge clk);
        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
